// File: rtl/iic_slave.sv
// I2C register-access target: 7-bit device address, 8-bit register pointer with
// auto-increment, single-clock write strobe, and read data shifted out from reg_rdata.
module iic_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, REG, ACK_REG, WDATA, ACK_WDATA, RDATA, MACK, IGNORE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  scl_sync_q, sda_sync_q;
  logic        scl_prev_q, sda_prev_q;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        sda_oe_q, sda_oe_d;
  logic        acked_q, acked_d;

  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rx_byte;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;
  assign rx_byte   = {shift_q[6:0], sda_s};

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      acked_q    <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      sda_oe_q   <= sda_oe_d;
      acked_q    <= acked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    sda_oe_d = sda_oe_q;
    acked_d  = acked_q;

    if (start_det) begin
      state_d  = DEV;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      bitcnt_d = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, IGNORE: ;
        DEV, REG, WDATA: begin
          if (scl_rise) begin
            shift_d  = rx_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              case (state_q)
                DEV:     state_d = (rx_byte[7:1] == DEV_ADDR) ? ACK_DEV : IGNORE;
                REG: begin
                  addr_d  = rx_byte;
                  state_d = ACK_REG;
                end
                default: begin
                  we_d    = 1'b1;
                  wdata_d = rx_byte;
                  state_d = ACK_WDATA;
                end
              endcase
            end
          end
        end
        // First scl fall after the byte starts the ack, the second one ends it.
        ACK_DEV, ACK_REG, ACK_WDATA: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              case (state_q)
                ACK_DEV: begin
                  if (shift_q[0]) begin
                    state_d  = RDATA;
                    shift_d  = reg_rdata;
                    sda_oe_d = ~reg_rdata[7];
                    bitcnt_d = '0;
                  end else begin
                    state_d = REG;
                  end
                end
                ACK_REG: state_d = WDATA;
                default: begin
                  addr_d  = addr_q + 8'd1;
                  state_d = WDATA;
                end
              endcase
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              bitcnt_d = '0;
              acked_d  = 1'b0;
              state_d  = MACK;
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            addr_d = addr_q + 8'd1;
            if (sda_s) state_d = IGNORE;
            else       acked_d = 1'b1;
          end else if (scl_fall && acked_q) begin
            state_d  = RDATA;
            shift_d  = reg_rdata;
            sda_oe_d = ~reg_rdata[7];
            bitcnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: bit-banged I2C initiator, register file model,
// write-strobe logger, and immediate-assertion checks.
module tb_iic_slave;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  wire        sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, busy;

  logic [7:0] regfile [256];
  logic [7:0] we_addr_log [16];
  logic [7:0] we_data_log [16];
  int         we_cnt = 0;
  int         low_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  assign sda_bus = m_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  assign reg_rdata = regfile[reg_addr];

  always #5 clk = ~clk;

  iic_slave #(.DEV_ADDR(7'h21)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda_bus),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (reg_we && we_cnt < 16) begin
      we_addr_log[we_cnt] <= reg_addr;
      we_data_log[we_cnt] <= reg_wdata;
    end
    if (reg_we) we_cnt <= we_cnt + 1;
    if (sda_bus === 1'b0 && !m_low) low_cnt <= low_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic recv_bit(output logic b);
    m_low = 1'b0;
    #Q scl = 1'b1;
    #Q b = sda_bus;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic i2c_start;
    m_low = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_rstart;
    m_low = 1'b0;
    #Q scl = 1'b1;
    #(2*Q) m_low = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    m_low = 1'b1;
    #Q scl = 1'b1;
    #(2*Q) m_low = 1'b0;
    #(2*Q);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    int         we0, low0;

    for (int i = 0; i < 256; i++) regfile[i] = 8'(i ^ 8'h5A);
    regfile[8'h10] = 8'hA5;
    regfile[8'h11] = 8'h3C;
    regfile[8'h20] = 8'h00;

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_we", reg_we, 1'b0);
    check("rst_sda", sda_bus, 1'b1);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // Write: 42 3A 5C
    we0 = we_cnt;
    i2c_start;
    check("wr_busy", busy, 1'b1);
    send_byte(8'h42, a); check("wr_ack_dev", a, 1'b0);
    send_byte(8'h3A, a); check("wr_ack_reg", a, 1'b0);
    send_byte(8'h5C, a); check("wr_ack_dat", a, 1'b0);
    i2c_stop;
    #100;
    check("wr_we_cnt", 32'(we_cnt - we0), 32'd1);
    check("wr_we_addr", we_addr_log[we0], 8'h3A);
    check("wr_we_data", we_data_log[we0], 8'h5C);
    check("wr_addr_end", reg_addr, 8'h3B);
    check("wr_busy_end", busy, 1'b0);

    // Random read: 42 10, rstart, 43, read A5 (ACK) 3C (NACK)
    we0 = we_cnt;
    i2c_start;
    send_byte(8'h42, a); check("rd_ack_dev", a, 1'b0);
    send_byte(8'h10, a); check("rd_ack_reg", a, 1'b0);
    i2c_rstart;
    send_byte(8'h43, a); check("rd_ack_dev_r", a, 1'b0);
    recv_byte(1'b0, d); check("rd_byte0", d, 8'hA5);
    recv_byte(1'b1, d); check("rd_byte1", d, 8'h3C);
    i2c_stop;
    #100;
    check("rd_addr_end", reg_addr, 8'h12);
    check("rd_no_we", 32'(we_cnt - we0), 32'd0);
    check("rd_busy_end", busy, 1'b0);

    // Address mismatch: 44 3A 5C
    we0 = we_cnt;
    low0 = low_cnt;
    i2c_start;
    send_byte(8'h44, a); check("mm_nack_dev", a, 1'b1);
    check("mm_busy", busy, 1'b1);
    send_byte(8'h3A, a); check("mm_nack_1", a, 1'b1);
    send_byte(8'h5C, a); check("mm_nack_2", a, 1'b1);
    i2c_stop;
    #100;
    check("mm_no_low", 32'(low_cnt - low0), 32'd0);
    check("mm_no_we", 32'(we_cnt - we0), 32'd0);
    check("mm_busy_end", busy, 1'b0);

    // Pointer wrap: 42 FF 11 22
    we0 = we_cnt;
    i2c_start;
    send_byte(8'h42, a);
    send_byte(8'hFF, a);
    send_byte(8'h11, a); check("wrap_ack0", a, 1'b0);
    send_byte(8'h22, a); check("wrap_ack1", a, 1'b0);
    i2c_stop;
    #100;
    check("wrap_we_cnt", 32'(we_cnt - we0), 32'd2);
    check("wrap_addr0", we_addr_log[we0], 8'hFF);
    check("wrap_data0", we_data_log[we0], 8'h11);
    check("wrap_addr1", we_addr_log[we0+1], 8'h00);
    check("wrap_data1", we_data_log[we0+1], 8'h22);
    check("wrap_addr_end", reg_addr, 8'h01);

    // Stop after 4 data bits
    we0 = we_cnt;
    i2c_start;
    send_byte(8'h42, a);
    send_byte(8'h50, a);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop;
    #100;
    check("part_no_we", 32'(we_cnt - we0), 32'd0);
    check("part_busy", busy, 1'b0);
    check("part_sda", sda_bus, 1'b1);
    check("part_addr", reg_addr, 8'h50);

    // Reset while the target drives a 0 data bit
    i2c_start;
    send_byte(8'h42, a);
    send_byte(8'h20, a);
    i2c_rstart;
    send_byte(8'h43, a);
    check("rr_drive_low", sda_bus, 1'b0);
    rst = 1'b0;
    #1;
    check("rr_sda_rel", sda_bus, 1'b1);
    check("rr_addr", reg_addr, 8'h00);
    check("rr_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    scl = 1'b1;
    #Q rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("rr_idle", busy, 1'b0);

    we0 = we_cnt;
    i2c_start;
    send_byte(8'h42, a); check("rr_wr_ack_dev", a, 1'b0);
    send_byte(8'h3A, a); check("rr_wr_ack_reg", a, 1'b0);
    send_byte(8'h5C, a); check("rr_wr_ack_dat", a, 1'b0);
    i2c_stop;
    #100;
    check("rr_we_cnt", 32'(we_cnt - we0), 32'd1);
    check("rr_we_addr", we_addr_log[we0], 8'h3A);
    check("rr_we_data", we_data_log[we0], 8'h5C);
    check("rr_addr_end", reg_addr, 8'h3B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
